tiny_clint: RTL and testbench
=============================

# tiny_clint

Memory-mapped core-local interruptor for the Kronos tiny SoC. It sits on the CPU data-memory port in parallel with the data SRAM and drives the core's `software_interrupt` and `timer_interrupt` inputs. It holds a 64-bit free-running `mtime` with a programmable prescaler, a 64-bit `mtimecmp` compare register, and an `msip` bit, all accessible through 32-bit word accesses with a bitwise write strobe.

## Interface
- `BaseAddr`, default `32'h0200_0000`: byte base of a 32-byte register window; must be 32-byte aligned.
- `PrescaleWidth`, default 16: width of the prescale register and counter, 1..32.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `data_mem_req_i`  in  1  access request.
- `data_mem_addr_i`  in  32  byte address; bits [1:0] ignored.
- `data_mem_we_i`  in  1  1 = write, 0 = read.
- `data_mem_wdata_i`  in  32  write data.
- `data_mem_strb_i`  in  32  bitwise write mask; 1 = bit written.
- `data_mem_gnt_o`  out  1  combinational grant, equal to `data_mem_req_i & sel`.
- `data_mem_rvalid_o`  out  1  registered; high one cycle after an accepted read.
- `data_mem_rdata_o`  out  32  registered read data.
- `int_software_o`  out  1  equals `msip`.
- `int_timer_o`  out  1  registered `mtime >= mtimecmp`.

## Operation
- `sel` = `(data_mem_addr_i & ~32'h1F) == BaseAddr`. An access is accepted when `data_mem_req_i & sel`. Requests with `sel = 0` have no effect: no write, and no rvalid pulse.
- Register offsets from `BaseAddr`:
  - 0x00 `MSIP`: bit 0 only; other bits read as 0.
  - 0x08 `MTIMECMP_LO`.
  - 0x0C `MTIMECMP_HI`.
  - 0x10 `MTIME_LO`.
  - 0x14 `MTIME_HI`.
  - 0x18 `PRESCALE`: low `PrescaleWidth` bits; other bits read as 0.
  - Offsets 0x04, 0x1C: read 0, writes ignored.
- Writes use a masked update: `reg <= (reg & ~strb) | (wdata & strb)`.
- Prescaler:
  - `pcnt` counts up each cycle.
  - When `pcnt == PRESCALE`, a tick occurs and `pcnt` returns to 0.
  - `PRESCALE = 0` ticks every cycle.
  - Writing `PRESCALE` clears `pcnt` to 0 in the same edge.
- `mtime` increments by 1 on each tick, as a full 64-bit add.
  - The carry from LO propagates into HI.
  - `0xFFFF_FFFF_FFFF_FFFF` wraps to 0.
- A write to `MTIME_LO` or `MTIME_HI` takes priority over a tick in that cycle:
  - The written half gets the masked value; the other half is held.
  - No increment occurs in that cycle.
  - `pcnt` is cleared to 0.
- Reads return the register value present in the accept cycle, before that edge's update.
- `MTIME` halves are read non-atomically; software handles the HI/LO/HI retry.

## Timing
- Reset values:
  - `mtime = 0`, `mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF`, `msip = 0`, `PRESCALE = 0`, `pcnt = 0`.
  - `data_mem_rvalid_o = 0`, `data_mem_rdata_o = 0`, `int_timer_o = 0`, `int_software_o = 0`.
- Reset asserted mid-operation reinitialises all state at the next edge. A read accepted in the cycle `rst_i` is high produces no rvalid pulse.
- Read latency is 1 cycle. `data_mem_rdata_o` holds its last value while `data_mem_rvalid_o` is 0.
- Back-to-back accesses are supported, one per cycle, with no stalls.
- `int_software_o` follows a write to `MSIP` in the next cycle.
- `int_timer_o` is registered from the current `mtime`/`mtimecmp`, so it lags those registers by 1 cycle.
- `int_timer_o` stays high while `mtime >= mtimecmp` (level, not pulse). It deasserts 1 cycle after a `mtimecmp` write makes the comparison false.

## Test plan
- Reset then read every offset:
  - `MTIMECMP_LO/HI` read `0xFFFFFFFF`.
  - `PRESCALE`, `MSIP` and 0x1C read 0.
  - `int_timer_o = int_software_o = 0`.
  - rvalid pulses exactly 1 cycle after each read.
- `PRESCALE = 0`: read `MTIME_LO` twice, 5 cycles apart, and get a difference of 5. With `PRESCALE = 3`: 8 cycles produce a difference of 2.
- Carry and wrap:
  - Write `MTIME_LO = 0xFFFFFFFE`, `MTIME_HI = 0`, `PRESCALE = 0`; after 2 ticks, `MTIME_HI = 1`, `MTIME_LO = 0`.
  - Write `MTIME_HI = 0xFFFFFFFF`, then `MTIME_LO = 0xFFFFFFFF`; after the next tick `MTIME` reads 0 in both halves.
- Timer interrupt:
  - With `mtime` near 0x10, write `MTIMECMP_HI = 0`, `MTIMECMP_LO = 0x20`; `int_timer_o` rises 1 cycle after `mtime` reaches 0x20.
  - Writing `MTIMECMP_LO = 0xFFFFFFFF` drops it 1 cycle later.
- Masked write: `MSIP` with `wdata = 1`, `strb = 0` leaves `int_software_o = 0`. With `strb = 1`, it rises next cycle; reading `MSIP` returns 1.
- Address and priority:
  - A write at `BaseAddr + 0x20` or `BaseAddr - 4` changes nothing and gives `gnt = 0`.
  - A write to `MTIME_LO` on a tick cycle stores exactly the written value, with no +1.

Source files
------------

// File: rtl/tiny_clint.sv
// tiny_clint: core-local interruptor with a prescaled 64-bit mtime, a 64-bit
// mtimecmp and a software-interrupt bit, on a 32-bit word bus with bit strobes.
module tiny_clint #(
    parameter logic [31:0] BaseAddr      = 32'h0200_0000,
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_mem_req_i,
    input  logic [31:0] data_mem_addr_i,
    input  logic        data_mem_we_i,
    input  logic [31:0] data_mem_wdata_i,
    input  logic [31:0] data_mem_strb_i,
    output logic        data_mem_gnt_o,
    output logic        data_mem_rvalid_o,
    output logic [31:0] data_mem_rdata_o,
    output logic        int_software_o,
    output logic        int_timer_o
);

    localparam logic [2:0] OffMsip     = 3'd0;
    localparam logic [2:0] OffCmpLo    = 3'd2;
    localparam logic [2:0] OffCmpHi    = 3'd3;
    localparam logic [2:0] OffMtimeLo  = 3'd4;
    localparam logic [2:0] OffMtimeHi  = 3'd5;
    localparam logic [2:0] OffPrescale = 3'd6;

    logic                     sel;
    logic                     accept;
    logic                     wr_en;
    logic                     rd_en;
    logic [2:0]               offset;
    logic                     wr_mtime_lo;
    logic                     wr_mtime_hi;
    logic                     wr_prescale;
    logic                     tick;
    logic                     msip;
    logic [63:0]              mtime;
    logic [63:0]              mtimecmp;
    logic [PrescaleWidth-1:0] prescale;
    logic [PrescaleWidth-1:0] pcnt;
    logic [31:0]              rd_value;
    logic [PrescaleWidth-1:0] strb_p;
    logic [PrescaleWidth-1:0] wdata_p;

    // Address decode and access qualification.
    assign sel            = (data_mem_addr_i & ~32'h1F) == BaseAddr;
    assign accept         = data_mem_req_i & sel;
    assign data_mem_gnt_o = accept;
    assign wr_en          = accept & data_mem_we_i;
    assign rd_en          = accept & ~data_mem_we_i;
    assign offset         = data_mem_addr_i[4:2];
    assign wr_mtime_lo    = wr_en & (offset == OffMtimeLo);
    assign wr_mtime_hi    = wr_en & (offset == OffMtimeHi);
    assign wr_prescale    = wr_en & (offset == OffPrescale);
    assign tick           = (pcnt == prescale);
    assign strb_p         = data_mem_strb_i[PrescaleWidth-1:0];
    assign wdata_p        = data_mem_wdata_i[PrescaleWidth-1:0];
    assign int_software_o = msip;

    // Read mux over the pre-update register values.
    always_comb begin
        rd_value = '0;
        case (offset)
            OffMsip:     rd_value = {31'b0, msip};
            OffCmpLo:    rd_value = mtimecmp[31:0];
            OffCmpHi:    rd_value = mtimecmp[63:32];
            OffMtimeLo:  rd_value = mtime[31:0];
            OffMtimeHi:  rd_value = mtime[63:32];
            OffPrescale: rd_value = 32'(prescale);
            default:     rd_value = '0;
        endcase
    end

    // Software interrupt bit and compare register, masked writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
        end else if (wr_en) begin
            if (offset == OffMsip) begin
                msip <= (msip & ~data_mem_strb_i[0]) | (data_mem_wdata_i[0] & data_mem_strb_i[0]);
            end
            if (offset == OffCmpLo) begin
                mtimecmp[31:0] <= (mtimecmp[31:0] & ~data_mem_strb_i)
                                | (data_mem_wdata_i & data_mem_strb_i);
            end
            if (offset == OffCmpHi) begin
                mtimecmp[63:32] <= (mtimecmp[63:32] & ~data_mem_strb_i)
                                 | (data_mem_wdata_i & data_mem_strb_i);
            end
        end
    end

    // Prescale register and its counter; any mtime or prescale write restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescale <= '0;
            pcnt     <= '0;
        end else begin
            if (wr_prescale) begin
                prescale <= (prescale & ~strb_p) | (wdata_p & strb_p);
            end
            if (wr_prescale || wr_mtime_lo || wr_mtime_hi || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PrescaleWidth'(1);
            end
        end
    end

    // mtime: software writes win over the tick increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= (mtime[31:0] & ~data_mem_strb_i) | (data_mem_wdata_i & data_mem_strb_i);
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= (mtime[63:32] & ~data_mem_strb_i) | (data_mem_wdata_i & data_mem_strb_i);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Read response and registered timer compare.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_mem_rvalid_o <= 1'b0;
            data_mem_rdata_o  <= '0;
            int_timer_o       <= 1'b0;
        end else begin
            data_mem_rvalid_o <= rd_en;
            if (rd_en) begin
                data_mem_rdata_o <= rd_value;
            end
            int_timer_o <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_tiny_clint.sv
// tb_tiny_clint: directed and randomized checks of tiny_clint against a
// behavioural register/time model.
module tb_tiny_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] strb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        int_sw;
    logic        int_tmr;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [63:0]     m_mtime;
    logic [63:0]     m_cmp;
    logic            m_msip;
    logic [15:0]     m_presc;
    longint unsigned m_since;
    logic            m_rvalid;
    logic [31:0]     m_rdata;
    logic            m_timer;

    tiny_clint #(.BaseAddr(BASE), .PrescaleWidth(16)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .data_mem_req_i    (req),
        .data_mem_addr_i   (addr),
        .data_mem_we_i     (we),
        .data_mem_wdata_i  (wdata),
        .data_mem_strb_i   (strb),
        .data_mem_gnt_o    (gnt),
        .data_mem_rvalid_o (rvalid),
        .data_mem_rdata_o  (rdata),
        .int_software_o    (int_sw),
        .int_timer_o       (int_tmr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] s);
        return (old & ~s) | (d & s);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0:    return {31'b0, m_msip};
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return m_mtime[31:0];
            3'd5:    return m_mtime[63:32];
            3'd6:    return {16'b0, m_presc};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_sel(input logic [31:0] a);
        return (a & ~32'h1F) == BASE;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic        acc;
        logic [2:0]  off;
        logic        tk;
        logic [63:0] nmt;
        longint unsigned nsince;
        logic [31:0] tmp;
        if (rst) begin
            m_mtime = 64'h0; m_cmp = '1; m_msip = 1'b0; m_presc = 16'h0; m_since = 0;
            m_rvalid = 1'b0; m_rdata = 32'h0; m_timer = 1'b0;
            return;
        end
        acc = req && m_sel(addr);
        off = addr[4:2];
        tk  = (m_since % (64'(m_presc) + 64'd1)) == 64'(m_presc);
        nmt = tk ? m_mtime + 64'd1 : m_mtime;
        nsince = m_since + 1;
        m_rvalid = acc && !we;
        if (m_rvalid) m_rdata = m_read(off);
        m_timer = (m_mtime >= m_cmp);
        if (acc && we) begin
            case (off)
                3'd0: begin tmp = merge({31'b0, m_msip}, wdata, strb); m_msip = tmp[0]; end
                3'd2: m_cmp[31:0]  = merge(m_cmp[31:0], wdata, strb);
                3'd3: m_cmp[63:32] = merge(m_cmp[63:32], wdata, strb);
                3'd4: begin nmt = {m_mtime[63:32], merge(m_mtime[31:0], wdata, strb)}; nsince = 0; end
                3'd5: begin nmt = {merge(m_mtime[63:32], wdata, strb), m_mtime[31:0]}; nsince = 0; end
                3'd6: begin tmp = merge({16'b0, m_presc}, wdata, strb); m_presc = tmp[15:0]; nsince = 0; end
                default: ;
            endcase
        end
        m_mtime = nmt;
        m_since = nsince;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] s);
        req = r; we = w; addr = a; wdata = d; strb = s;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (n) step();
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [31:0] s);
        drive(1'b1, 1'b1, BASE + 32'(off), d, s);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] got, output logic gotv,
                      output logic [31:0] exp);
        drive(1'b1, 1'b0, a, 32'h0, 32'h0);
        exp = m_read(a[4:2]);
        step();
        got = rdata;
        gotv = rvalid;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] got, exp, cexp;
        logic v;
        logic [31:0] consts [8];
        consts = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        rst = 1'b1;
        idle(2);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (int_tmr !== 1'b0) begin errors++; $display("FAIL reset_timer: got %b expected 0", int_tmr); end
        checks++; if (int_sw !== 1'b0) begin errors++; $display("FAIL reset_sw: got %b expected 0", int_sw); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(BASE + 32'(i * 4), got, v, exp);
            cexp = (i == 4) ? exp : consts[i];
            checks++; if (v !== 1'b1) begin errors++; $display("FAIL reset_read_rvalid[%0d]: got %b expected 1", i, v); end
            checks++; if (got !== cexp) begin errors++; $display("FAIL reset_read[%0d]: got %h expected %h", i, got, cexp); end
        end
        idle(1);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_single_pulse: got %b expected 0", rvalid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_hold: got %h expected 0", rdata); end
    endtask

    task automatic test_prescale();
        logic [31:0] a, b, e;
        logic v;
        wr(8'h18, 32'h0, 32'hFFFF_FFFF);
        rd(BASE + 32'h10, a, v, e);
        checks++; if (a !== e) begin errors++; $display("FAIL presc0_first: got %h expected %h", a, e); end
        idle(4);
        rd(BASE + 32'h10, b, v, e);
        checks++; if (b - a !== 32'd5) begin errors++; $display("FAIL presc0_delta: got %0d expected 5", b - a); end
        wr(8'h18, 32'h3, 32'hFFFF_FFFF);
        rd(BASE + 32'h10, a, v, e);
        idle(7);
        rd(BASE + 32'h10, b, v, e);
        checks++; if (b - a !== 32'd2) begin errors++; $display("FAIL presc3_delta: got %0d expected 2", b - a); end
        checks++; if (b !== e) begin errors++; $display("FAIL presc3_model: got %h expected %h", b, e); end
        rd(BASE + 32'h18, a, v, e);
        checks++; if (a !== 32'h3) begin errors++; $display("FAIL presc_readback: got %h expected 3", a); end
    endtask

    task automatic test_carry_wrap();
        logic [31:0] got, e;
        logic v;
        wr(8'h18, 32'h0, 32'hFFFF_FFFF);
        wr(8'h10, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        wr(8'h14, 32'h0, 32'hFFFF_FFFF);
        idle(2);
        rd(BASE + 32'h10, got, v, e);
        checks++; if (got !== 32'h0) begin errors++; $display("FAIL carry_lo: got %h expected 0", got); end
        rd(BASE + 32'h14, got, v, e);
        checks++; if (got !== 32'h1) begin errors++; $display("FAIL carry_hi: got %h expected 1", got); end
        wr(8'h14, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wr(8'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(1);
        rd(BASE + 32'h10, got, v, e);
        checks++; if (got !== 32'h0) begin errors++; $display("FAIL wrap_lo: got %h expected 0", got); end
        rd(BASE + 32'h14, got, v, e);
        checks++; if (got !== 32'h0) begin errors++; $display("FAIL wrap_hi: got %h expected 0", got); end
    endtask

    task automatic test_priority();
        logic [31:0] got, e;
        logic v;
        wr(8'h10, 32'h1234_5678, 32'hFFFF_FFFF);
        rd(BASE + 32'h10, got, v, e);
        checks++; if (got !== 32'h1234_5678) begin errors++; $display("FAIL write_over_tick: got %h expected 12345678", got); end
        wr(8'h14, 32'hAAAA_AAAA, 32'h0000_FFFF);
        rd(BASE + 32'h14, got, v, e);
        checks++; if (got !== 32'h0000_AAAA) begin errors++; $display("FAIL masked_mtime_hi: got %h expected 0000aaaa", got); end
    endtask

    task automatic test_timer();
        int rise;
        wr(8'h18, 32'h0, 32'hFFFF_FFFF);
        wr(8'h14, 32'h0, 32'hFFFF_FFFF);
        wr(8'h10, 32'h10, 32'hFFFF_FFFF);
        wr(8'h0C, 32'h0, 32'hFFFF_FFFF);
        wr(8'h08, 32'h20, 32'hFFFF_FFFF);
        checks++; if (int_tmr !== 1'b0) begin errors++; $display("FAIL timer_low_before: got %b expected 0", int_tmr); end
        rise = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            checks++; if (int_tmr !== m_timer) begin errors++; $display("FAIL timer_track[%0d]: got %b expected %b", k, int_tmr, m_timer); end
            if (int_tmr === 1'b1) begin rise = k; break; end
        end
        checks++; if (rise != 15) begin errors++; $display("FAIL timer_rise_cycle: got %0d expected 15", rise); end
        idle(2);
        checks++; if (int_tmr !== 1'b1) begin errors++; $display("FAIL timer_level: got %b expected 1", int_tmr); end
        wr(8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (int_tmr !== 1'b1) begin errors++; $display("FAIL timer_lag: got %b expected 1", int_tmr); end
        idle(1);
        checks++; if (int_tmr !== 1'b0) begin errors++; $display("FAIL timer_drop: got %b expected 0", int_tmr); end
    endtask

    task automatic test_msip();
        logic [31:0] got, e;
        logic v;
        wr(8'h00, 32'h1, 32'h0);
        checks++; if (int_sw !== 1'b0) begin errors++; $display("FAIL msip_strb0: got %b expected 0", int_sw); end
        idle(1);
        checks++; if (int_sw !== 1'b0) begin errors++; $display("FAIL msip_strb0_hold: got %b expected 0", int_sw); end
        wr(8'h00, 32'h1, 32'h1);
        checks++; if (int_sw !== 1'b1) begin errors++; $display("FAIL msip_set: got %b expected 1", int_sw); end
        rd(BASE, got, v, e);
        checks++; if (got !== 32'h1) begin errors++; $display("FAIL msip_read: got %h expected 1", got); end
        wr(8'h00, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        checks++; if (int_sw !== 1'b1) begin errors++; $display("FAIL msip_mask_bit0: got %b expected 1", int_sw); end
    endtask

    task automatic test_address();
        drive(1'b1, 1'b1, BASE + 32'h20, 32'h0, 32'hFFFF_FFFF);
        #1;
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL gnt_above: got %b expected 0", gnt); end
        step();
        checks++; if (int_sw !== 1'b1) begin errors++; $display("FAIL write_above: got %b expected 1", int_sw); end
        drive(1'b1, 1'b1, BASE - 32'h4, 32'h0, 32'hFFFF_FFFF);
        #1;
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL gnt_below: got %b expected 0", gnt); end
        step();
        checks++; if (int_sw !== 1'b1) begin errors++; $display("FAIL write_below: got %b expected 1", int_sw); end
        drive(1'b1, 1'b0, BASE + 32'h20, 32'h0, 32'h0);
        #1;
        step();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL read_unselected: got %b expected 0", rvalid); end
        drive(1'b1, 1'b0, BASE + 32'h13, 32'h0, 32'h0);
        #1;
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL gnt_low_bits: got %b expected 1", gnt); end
        step();
        checks++; if (rvalid !== 1'b1 || rdata !== m_rdata) begin
            errors++; $display("FAIL read_low_bits: got %b/%h expected 1/%h", rvalid, rdata, m_rdata);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, e;
        logic v;
        wr(8'h08, 32'h5A5A, 32'hFFFF_FFFF);
        rd(BASE + 32'h08, got, v, e);
        checks++; if (got !== 32'h0000_5A5A || v !== 1'b1) begin errors++; $display("FAIL b2b_cmp_lo: got %b/%h expected 1/00005a5a", v, got); end
        rd(BASE + 32'h0C, got, v, e);
        checks++; if (got !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL b2b_cmp_hi: got %b/%h expected 1/0", v, got); end
        rd(BASE + 32'h18, got, v, e);
        checks++; if (got !== e || v !== 1'b1) begin errors++; $display("FAIL b2b_presc: got %b/%h expected 1/%h", v, got, e); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        drive(1'b1, 1'b0, BASE + 32'h08, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_read_rvalid: got %b expected 0", rvalid); end
        checks++; if (int_sw !== 1'b0) begin errors++; $display("FAIL reset_mid_sw: got %b expected 0", int_sw); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_mid_rdata: got %h expected 0", rdata); end
    endtask

    task automatic test_random();
        logic [2:0]  off;
        logic [31:0] a, d, s;
        logic        expg;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            off = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) == 0) ? BASE + 32'h20 + 32'($urandom_range(0, 15) * 4)
                                                 : BASE - 32'($urandom_range(1, 8) * 4);
            else
                a = BASE + {27'b0, off, 2'($urandom_range(0, 3))};
            case (off)
                3'd6:       d = 32'($urandom_range(0, 3)) | ($urandom_range(0, 1) == 0 ? 32'hFFFF_0000 : 32'h0);
                3'd3, 3'd5: d = 32'($urandom_range(0, 1));
                default:    d = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0:       s = 32'hFFFF_FFFF;
                1:       s = 32'h0;
                default: s = $urandom;
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d, s);
            expg = req && m_sel(a);
            #1;
            checks++; if (gnt !== expg) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", n, gnt, expg); end
            step();
            checks++; if (rvalid !== m_rvalid) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", n, rvalid, m_rvalid); end
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, rdata, m_rdata); end
            checks++; if (int_tmr !== m_timer) begin errors++; $display("FAIL rnd_timer[%0d]: got %b expected %b", n, int_tmr, m_timer); end
            checks++; if (int_sw !== m_msip) begin errors++; $display("FAIL rnd_sw[%0d]: got %b expected %b", n, int_sw, m_msip); end
        end
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        m_mtime = 64'h0; m_cmp = '1; m_msip = 1'b0; m_presc = 16'h0; m_since = 0;
        m_rvalid = 1'b0; m_rdata = 32'h0; m_timer = 1'b0;
        #1;
        test_reset();
        test_prescale();
        test_carry_wrap();
        test_priority();
        test_timer();
        test_msip();
        test_address();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
